// File: rtl/dcache_pkg.sv
// Shared types and field positions for the 2-way L1 data cache controller.
// Tag word layout is {valid, dirty, tag}; address is {tag, index, word, byte}.
package dcache_pkg;

  localparam int TAG_W    = 23;
  localparam int IDX_W    = 4;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int WSEL_W   = 3;
  localparam int OFF_W    = 5;
  localparam int TWORD_W  = TAG_W + 2;
  localparam int LADDR_W  = TAG_W + IDX_W;

  localparam int VALID    = 24;
  localparam int DIRTY    = 23;
  localparam int TAG_LSB  = 9;
  localparam int IDX_LSB  = 5;
  localparam int WSEL_LSB = 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    READMISS,
    REFILL
  } state_t;

  typedef logic [TWORD_W-1:0] tag_word_t;
  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [WORD_W-1:0]  word_t;

  function automatic tag_word_t mk_tag(
    input logic             dirty,
    input logic [TAG_W-1:0] tag
  );
    return {1'b1, dirty, tag};
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Word select and word replace on a 256-bit cache line.
// Pure combinational helper for the controller's load and store-hit paths.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  line_t             line,
  input  logic [WSEL_W-1:0] sel,
  input  word_t             wdata,
  output word_t             rword,
  output line_t             merged
);

  logic [7:0] base;

  assign base  = {sel, 5'b0};
  assign rword = line[base +: WORD_W];

  always_comb begin
    merged = line;
    merged[base +: WORD_W] = wdata;
  end

endmodule

// File: rtl/dcache_controller.sv
// L1 data cache controller: hit service, dirty writeback and line refill.
// Sits between the MEM stage and the main-memory line interface.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         cpu_addr_i,
  input  word_t               cpu_data_i,
  input  logic                cpu_MemRead_i,
  input  logic                cpu_MemWrite_i,
  output word_t               cpu_data_o,
  output logic                cpu_stall_o,
  output logic [IDX_W-1:0]    sram_addr_o,
  output tag_word_t           sram_tag_o,
  output line_t               sram_data_o,
  output logic                sram_enable_o,
  output logic                sram_write_o,
  input  tag_word_t           sram_tag_i,
  input  line_t               sram_data_i,
  input  logic                sram_hit_i,
  input  line_t               mem_data_i,
  input  logic                mem_ack_i,
  output line_t               mem_data_o,
  output logic [31:0]         mem_addr_o,
  output logic                mem_enable_o,
  output logic                mem_write_o
);

  state_t state;
  state_t state_nx;

  logic [TAG_W-1:0]   victim_tag;
  line_t              victim_line;
  line_t              refill_buf;
  logic [LADDR_W-1:0] miss_line;

  logic               req;
  logic               store;
  logic               victim_dirty;
  logic               miss_start;
  logic [LADDR_W-1:0] req_line;
  logic [LADDR_W-1:0] cur_line;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   line_tag;
  word_t              rword;
  line_t              merged;
  logic               addr_unused;

  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign store        = cpu_MemWrite_i;
  assign victim_dirty = sram_tag_i[VALID] & sram_tag_i[DIRTY];
  assign miss_start   = (state == IDLE) & req & ~sram_hit_i;
  assign req_line     = cpu_addr_i[31:OFF_W];
  assign addr_unused  = ^cpu_addr_i[WSEL_LSB-1:0];

  // The miss line is held so a request dropped mid-miss still
  // writes back and refills the set it started on.
  assign cur_line = (state == IDLE) ? req_line : miss_line;
  assign idx      = cur_line[IDX_W-1:0];
  assign line_tag = cur_line[LADDR_W-1:IDX_W];

  dcache_word_merge u_merge (
    .line   (sram_data_i),
    .sel    (cpu_addr_i[WSEL_LSB +: WSEL_W]),
    .wdata  (cpu_data_i),
    .rword  (rword),
    .merged (merged)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      victim_tag  <= '0;
      victim_line <= '0;
      refill_buf  <= '0;
      miss_line   <= '0;
    end else begin
      state <= state_nx;
      if (miss_start) begin
        victim_tag  <= sram_tag_i[TAG_W-1:0];
        victim_line <= sram_data_i;
        miss_line   <= req_line;
      end
      if (state == READMISS && mem_ack_i) begin
        refill_buf <= mem_data_i;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_addr_o   = '0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    mem_data_o    = '0;
    mem_addr_o    = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    if (rst_i) begin
      sram_addr_o   = idx;
      sram_enable_o = req | (state != IDLE);
      unique case (state)
        IDLE: begin
          if (req && sram_hit_i) begin
            if (store) begin
              sram_write_o = 1'b1;
              sram_data_o  = merged;
              sram_tag_o   = mk_tag(1'b1, line_tag);
            end else begin
              cpu_data_o = rword;
            end
          end else if (req) begin
            cpu_stall_o = 1'b1;
            state_nx    = victim_dirty ? WRITEBACK : READMISS;
          end
        end
        WRITEBACK: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {victim_tag, idx, {OFF_W{1'b0}}};
          mem_data_o   = victim_line;
          if (mem_ack_i) state_nx = READMISS;
        end
        READMISS: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_addr_o   = {cur_line, {OFF_W{1'b0}}};
          if (mem_ack_i) state_nx = REFILL;
        end
        REFILL: begin
          cpu_stall_o  = 1'b1;
          sram_write_o = 1'b1;
          sram_tag_o   = mk_tag(1'b0, line_tag);
          sram_data_o  = refill_buf;
          state_nx     = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: SRAM and memory models plus a flat-memory
// reference; loads are scoreboarded, miss traffic is checked directly.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic         cpu_rd = 1'b0;
  logic         cpu_wr = 1'b0;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic [3:0]   sram_addr;
  logic [24:0]  sram_tag_w;
  logic [255:0] sram_data_w;
  logic         sram_en;
  logic         sram_we;
  logic [24:0]  sram_tag_r;
  logic [255:0] sram_data_r;
  logic         sram_hit;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_addr;
  logic         mem_en;
  logic         mem_we;

  int checks = 0;
  int fails = 0;

  dcache_controller dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .cpu_addr_i     (cpu_addr),
    .cpu_data_i     (cpu_wdata),
    .cpu_MemRead_i  (cpu_rd),
    .cpu_MemWrite_i (cpu_wr),
    .cpu_data_o     (cpu_rdata),
    .cpu_stall_o    (cpu_stall),
    .sram_addr_o    (sram_addr),
    .sram_tag_o     (sram_tag_w),
    .sram_data_o    (sram_data_w),
    .sram_enable_o  (sram_en),
    .sram_write_o   (sram_we),
    .sram_tag_i     (sram_tag_r),
    .sram_data_i    (sram_data_r),
    .sram_hit_i     (sram_hit),
    .mem_data_i     (mem_rdata),
    .mem_ack_i      (mem_ack),
    .mem_data_o     (mem_wdata),
    .mem_addr_o     (mem_addr),
    .mem_enable_o   (mem_en),
    .mem_write_o    (mem_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Reference: flat word-addressed memory, what the CPU must observe
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word({a[31:2], 2'b00});
  endfunction

  // Main memory model
  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mtx_t;

  mtx_t         mem_log[$];
  logic [255:0] mline [logic [26:0]];
  int           lat = 3;
  bit           mbusy = 0;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mline.exists(a[31:5])) return mline[a[31:5]];
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = init_word({a[31:5], 5'b0} + 32'(w * 4));
    return l;
  endfunction

  initial begin : mem_model
    int   cnt;
    mtx_t cur;
    cnt = 0;
    forever begin
      @(posedge clk);
      mem_ack <= 1'b0;
      if (mbusy) begin
        if (cnt <= 1) begin
          mbusy = 0;
          mem_ack <= 1'b1;
          if (cur.wr) mline[cur.addr[31:5]] = cur.data;
          else begin
            cur.data = line_of(cur.addr);
            mem_rdata <= cur.data;
          end
          mem_log.push_back(cur);
        end else cnt--;
      end else if (mem_en && !mem_ack) begin
        cur.wr   = mem_we;
        cur.addr = mem_addr;
        cur.data = mem_wdata;
        cnt      = lat;
        mbusy    = 1;
      end
    end
  end

  // 2-way SRAM model with per-set LRU
  typedef struct {
    logic [3:0]   idx;
    logic [24:0]  tag;
    logic [255:0] data;
  } stx_t;

  stx_t         sram_log[$];
  logic [24:0]  stag [2][16] = '{default: '0};
  logic [255:0] sdat [2][16] = '{default: '0};
  logic         slru [16] = '{default: 1'b0};
  logic         s_way;
  logic         h0;
  logic         h1;

  always_comb begin
    h0 = stag[0][sram_addr][24] && stag[0][sram_addr][22:0] == cpu_addr[31:9];
    h1 = stag[1][sram_addr][24] && stag[1][sram_addr][22:0] == cpu_addr[31:9];
    sram_hit = h0 | h1;
    s_way = h0 ? 1'b0 : (h1 ? 1'b1 : slru[sram_addr]);
    sram_tag_r = stag[s_way][sram_addr];
    sram_data_r = sdat[s_way][sram_addr];
  end

  always @(posedge clk) begin
    if (sram_en && sram_we) begin
      stag[s_way][sram_addr] <= sram_tag_w;
      sdat[s_way][sram_addr] <= sram_data_w;
      slru[sram_addr] <= ~s_way;
      sram_log.push_back('{sram_addr, sram_tag_w, sram_data_w});
    end else if (sram_en && sram_hit) begin
      slru[sram_addr] <= ~s_way;
    end
  end

  function automatic int find_way(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (stag[w][a[8:5]][24] && stag[w][a[8:5]][22:0] == a[31:9]) return w;
    return -1;
  endfunction

  // Scoreboard
  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (cpu_rd || cpu_wr) && !cpu_stall) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: completion at %0h with no request queued", cpu_addr);
      end else begin
        e = sb.pop_front();
        if (e.is_load) chk("load_data", cpu_rdata, e.data);
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                        input bit wr, output int stalls,
                        output logic [31:0] rdata);
    exp_t e;
    e.is_load = !wr;
    e.addr = a;
    e.data = '0;
    if (wr) ref_mem[a[31:2]] = d;
    else e.data = ref_rd(a);
    sb.push_back(e);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_rd = !wr;
    cpu_wr = wr;
    stalls = 0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        break;
      end
      stalls++;
      if (stalls > 500) begin
        chk("req_timeout", 32'(stalls), 0);
        void'(sb.pop_back());
        break;
      end
    end
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int          st;
    int          w;
    int          n;
    logic [31:0] rv;
    logic [31:0] a;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_sram_en", {sram_en, sram_we}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {cpu_stall, mem_en, mem_we, sram_en, sram_we, cpu_rdata}, 0);
    @(posedge clk);
    #1;

    // cold load miss, slow memory
    lat = 10;
    mem_log.delete();
    sram_log.delete();
    do_req(32'h400, 0, 0, st, rv);
    chk("c2_mem_txns", mem_log.size(), 1);
    if (mem_log.size() > 0) chk("c2_read", {mem_log[0].wr, mem_log[0].addr}, {1'b0, 32'h400});
    chk("c2_sram_writes", sram_log.size(), 1);
    if (sram_log.size() > 0) chk("c2_refill_tag", sram_log[0].tag, {2'b10, 23'h2});
    chk("c2_word0", rv, init_word(32'h400));

    // store hit
    lat = 3;
    mem_log.delete();
    do_req(32'h404, 32'hDEADBEEF, 1, st, rv);
    chk("c3_no_stall", st, 0);
    chk("c3_no_mem", mem_log.size(), 0);
    w = find_way(32'h404);
    chk("c3_present", 32'(w >= 0), 1);
    if (w < 0) w = 0;
    chk("c3_tag", stag[w][0], {2'b11, 23'h2});
    chk("c3_word1", sdat[w][0][63:32], 32'hDEADBEEF);

    // conflict in set 0 evicts the dirty 0x400 line
    mem_log.delete();
    do_req(32'h600, 0, 0, st, rv);
    chk("c4_first_txns", mem_log.size(), 1);
    mem_log.delete();
    do_req(32'h800, 0, 0, st, rv);
    chk("c4_txns", mem_log.size(), 2);
    if (mem_log.size() == 2) begin
      chk("c4_wb", {mem_log[0].wr, mem_log[0].addr}, {1'b1, 32'h400});
      chk("c4_wb_word1", mem_log[0].data[63:32], 32'hDEADBEEF);
      chk("c4_rd", {mem_log[1].wr, mem_log[1].addr}, {1'b0, 32'h800});
    end

    // store miss
    mem_log.delete();
    sram_log.delete();
    do_req(32'h1024, 32'h1234_5678, 1, st, rv);
    chk("c5_txns", mem_log.size(), 1);
    if (mem_log.size() > 0) chk("c5_read", {mem_log[0].wr, mem_log[0].addr}, {1'b0, 32'h1020});
    chk("c5_sram_writes", sram_log.size(), 2);
    if (sram_log.size() > 0) chk("c5_refill_tag", sram_log[0].tag, {2'b10, 23'h8});
    w = find_way(32'h1024);
    chk("c5_present", 32'(w >= 0), 1);
    if (w < 0) w = 0;
    chk("c5_tag", stag[w][1], {2'b11, 23'h8});
    chk("c5_word1", sdat[w][1][63:32], 32'h1234_5678);

    // long-latency miss: request held stable
    lat = 50;
    fork
      do_req(32'h2040, 0, 0, st, rv);
      begin
        n = 0;
        while (!mem_en && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 45; k++) begin
          @(negedge clk);
          chk("c6_hold", {mem_en, mem_we, cpu_stall, mem_addr},
              {1'b1, 1'b0, 1'b1, 32'h2040});
        end
      end
    join

    // random traffic over a few conflicting sets
    for (int k = 0; k < 300; k++) begin
      a = {23'($urandom_range(0, 5)), 4'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'b00};
      d = $urandom;
      lat = $urandom_range(1, 6);
      do_req(a, d, bit'($urandom_range(0, 1)), st, rv);
    end

    // reset in the middle of a writeback
    lat = 3;
    do_req(32'h7000, 32'hA1A1_0001, 1, st, rv);
    do_req(32'h7200, 32'hB2B2_0002, 1, st, rv);
    lat = 30;
    cpu_addr = 32'h7400;
    cpu_rd = 1'b1;
    n = 0;
    while (!(mem_en && mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("c1_wb_started", {mem_en, mem_we, mem_addr}, {2'b11, 32'h7000});
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("c1_async_drop", mem_en, 0);
    cpu_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("c1_idle_after", {cpu_stall, mem_en, sram_en}, 0);
    end
    @(posedge clk);
    #1;
    lat = 2;
    do_req(32'h7000, 0, 0, st, rv);
    do_req(32'h7400, 0, 0, st, rv);
    do_req(32'h7200, 0, 0, st, rv);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
